// File: rtl/nasti_arb_pkg.sv
// Shared types and the round-robin pick function for the NASTI memory arbiter.
package nasti_arb_pkg;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wr_state_e;
    typedef enum logic       {R_IDLE, R_ADDR}         rd_state_e;

    localparam int MAX_MST = 16;

    // First set bit of req at or after ptr, wrapping within n (n a power of two).
    // The descending scan lets the smallest offset win.
    function automatic logic [3:0] rr_pick(input logic [MAX_MST-1:0] req,
                                           input logic [3:0] ptr, input int n);
        logic [3:0] idx;
        rr_pick = ptr;
        for (int k = MAX_MST - 1; k >= 0; k--) begin
            idx = 4'(int'(ptr) + k) & 4'(n - 1);
            if (k < n && req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/nasti_rr_arb.sv
// Round-robin grant register: lock captures a winner, rel advances the pointer past it.
module nasti_rr_arb
    import nasti_arb_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         lock,
    input  logic         rel,
    output logic [W-1:0] grant
);

    logic [W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
            ptr   <= '0;
        end else begin
            if (lock) grant <= W'(rr_pick(MAX_MST'(req), 4'(ptr), N));
            if (rel)  ptr   <= grant + 1'b1;
        end
    end

endmodule

// File: rtl/nasti_mem_arbiter.sv
// Shares one NASTI slave port between NUM_MST masters; AW/AR arbitrated independently,
// W locked to the AW winner until w_last, B/R routed by the master index in the ID MSBs.
module nasti_mem_arbiter
    import nasti_arb_pkg::*;
#(
    parameter  int NUM_MST    = 2,
    parameter  int ID_WIDTH   = 1,
    parameter  int ADDR_WIDTH = 64,
    parameter  int DATA_WIDTH = 64,
    parameter  int USER_WIDTH = 1,
    localparam int MST_W      = $clog2(NUM_MST),
    localparam int SID_W      = ID_WIDTH + MST_W,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic clk,
    input  logic rst,
    // master-facing ports
    input  logic [NUM_MST-1:0]                 mst_aw_valid,
    output logic [NUM_MST-1:0]                 mst_aw_ready,
    input  logic [NUM_MST-1:0][ID_WIDTH-1:0]   mst_aw_id,
    input  logic [NUM_MST-1:0][ADDR_WIDTH-1:0] mst_aw_addr,
    input  logic [NUM_MST-1:0][7:0]            mst_aw_len,
    input  logic [NUM_MST-1:0][2:0]            mst_aw_size,
    input  logic [NUM_MST-1:0][1:0]            mst_aw_burst,
    input  logic [NUM_MST-1:0][USER_WIDTH-1:0] mst_aw_user,
    input  logic [NUM_MST-1:0]                 mst_w_valid,
    output logic [NUM_MST-1:0]                 mst_w_ready,
    input  logic [NUM_MST-1:0][DATA_WIDTH-1:0] mst_w_data,
    input  logic [NUM_MST-1:0][STRB_W-1:0]     mst_w_strb,
    input  logic [NUM_MST-1:0]                 mst_w_last,
    input  logic [NUM_MST-1:0][USER_WIDTH-1:0] mst_w_user,
    output logic [NUM_MST-1:0]                 mst_b_valid,
    input  logic [NUM_MST-1:0]                 mst_b_ready,
    output logic [NUM_MST-1:0][ID_WIDTH-1:0]   mst_b_id,
    output logic [NUM_MST-1:0][1:0]            mst_b_resp,
    output logic [NUM_MST-1:0][USER_WIDTH-1:0] mst_b_user,
    input  logic [NUM_MST-1:0]                 mst_ar_valid,
    output logic [NUM_MST-1:0]                 mst_ar_ready,
    input  logic [NUM_MST-1:0][ID_WIDTH-1:0]   mst_ar_id,
    input  logic [NUM_MST-1:0][ADDR_WIDTH-1:0] mst_ar_addr,
    input  logic [NUM_MST-1:0][7:0]            mst_ar_len,
    input  logic [NUM_MST-1:0][2:0]            mst_ar_size,
    input  logic [NUM_MST-1:0][1:0]            mst_ar_burst,
    input  logic [NUM_MST-1:0][USER_WIDTH-1:0] mst_ar_user,
    output logic [NUM_MST-1:0]                 mst_r_valid,
    input  logic [NUM_MST-1:0]                 mst_r_ready,
    output logic [NUM_MST-1:0][ID_WIDTH-1:0]   mst_r_id,
    output logic [NUM_MST-1:0][DATA_WIDTH-1:0] mst_r_data,
    output logic [NUM_MST-1:0][1:0]            mst_r_resp,
    output logic [NUM_MST-1:0]                 mst_r_last,
    output logic [NUM_MST-1:0][USER_WIDTH-1:0] mst_r_user,
    // memory-facing port
    output logic                  slv_aw_valid,
    input  logic                  slv_aw_ready,
    output logic [SID_W-1:0]      slv_aw_id,
    output logic [ADDR_WIDTH-1:0] slv_aw_addr,
    output logic [7:0]            slv_aw_len,
    output logic [2:0]            slv_aw_size,
    output logic [1:0]            slv_aw_burst,
    output logic [USER_WIDTH-1:0] slv_aw_user,
    output logic                  slv_w_valid,
    input  logic                  slv_w_ready,
    output logic [DATA_WIDTH-1:0] slv_w_data,
    output logic [STRB_W-1:0]     slv_w_strb,
    output logic                  slv_w_last,
    output logic [USER_WIDTH-1:0] slv_w_user,
    input  logic                  slv_b_valid,
    output logic                  slv_b_ready,
    input  logic [SID_W-1:0]      slv_b_id,
    input  logic [1:0]            slv_b_resp,
    input  logic [USER_WIDTH-1:0] slv_b_user,
    output logic                  slv_ar_valid,
    input  logic                  slv_ar_ready,
    output logic [SID_W-1:0]      slv_ar_id,
    output logic [ADDR_WIDTH-1:0] slv_ar_addr,
    output logic [7:0]            slv_ar_len,
    output logic [2:0]            slv_ar_size,
    output logic [1:0]            slv_ar_burst,
    output logic [USER_WIDTH-1:0] slv_ar_user,
    input  logic                  slv_r_valid,
    output logic                  slv_r_ready,
    input  logic [SID_W-1:0]      slv_r_id,
    input  logic [DATA_WIDTH-1:0] slv_r_data,
    input  logic [1:0]            slv_r_resp,
    input  logic                  slv_r_last,
    input  logic [USER_WIDTH-1:0] slv_r_user
);

    wr_state_e        wr_state, wr_next;
    rd_state_e        rd_state, rd_next;
    logic [MST_W-1:0] aw_gnt, ar_gnt, b_sel, r_sel;
    logic             aw_lock, aw_rel, ar_lock, ar_rel;

    assign aw_lock = (wr_state == W_IDLE) && (|mst_aw_valid);
    assign aw_rel  = (wr_state == W_DATA) && slv_w_valid && slv_w_ready && slv_w_last;
    assign ar_lock = (rd_state == R_IDLE) && (|mst_ar_valid);
    assign ar_rel  = (rd_state == R_ADDR) && slv_ar_valid && slv_ar_ready;

    nasti_rr_arb #(.N(NUM_MST)) u_aw_arb (
        .clk(clk), .rst(rst), .req(mst_aw_valid), .lock(aw_lock), .rel(aw_rel), .grant(aw_gnt)
    );

    nasti_rr_arb #(.N(NUM_MST)) u_ar_arb (
        .clk(clk), .rst(rst), .req(mst_ar_valid), .lock(ar_lock), .rel(ar_rel), .grant(ar_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (|mst_aw_valid) wr_next = W_ADDR;
            W_ADDR:  if (slv_aw_valid && slv_aw_ready) wr_next = W_DATA;
            W_DATA:  if (aw_rel) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (|mst_ar_valid) rd_next = R_ADDR;
            R_ADDR:  if (ar_rel) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        slv_aw_valid = 1'b0;
        mst_aw_ready = '0;
        slv_w_valid  = 1'b0;
        mst_w_ready  = '0;
        slv_ar_valid = 1'b0;
        mst_ar_ready = '0;
        case (wr_state)
            W_ADDR: begin
                slv_aw_valid         = mst_aw_valid[aw_gnt];
                mst_aw_ready[aw_gnt] = slv_aw_ready;
            end
            W_DATA: begin
                slv_w_valid         = mst_w_valid[aw_gnt];
                mst_w_ready[aw_gnt] = slv_w_ready;
            end
            default: ;
        endcase
        if (rd_state == R_ADDR) begin
            slv_ar_valid         = mst_ar_valid[ar_gnt];
            mst_ar_ready[ar_gnt] = slv_ar_ready;
        end
    end

    // Payload follows the registered grant; only the valid is state-gated.
    assign slv_aw_id    = {aw_gnt, mst_aw_id[aw_gnt]};
    assign slv_aw_addr  = mst_aw_addr[aw_gnt];
    assign slv_aw_len   = mst_aw_len[aw_gnt];
    assign slv_aw_size  = mst_aw_size[aw_gnt];
    assign slv_aw_burst = mst_aw_burst[aw_gnt];
    assign slv_aw_user  = mst_aw_user[aw_gnt];
    assign slv_w_data   = mst_w_data[aw_gnt];
    assign slv_w_strb   = mst_w_strb[aw_gnt];
    assign slv_w_last   = mst_w_last[aw_gnt];
    assign slv_w_user   = mst_w_user[aw_gnt];
    assign slv_ar_id    = {ar_gnt, mst_ar_id[ar_gnt]};
    assign slv_ar_addr  = mst_ar_addr[ar_gnt];
    assign slv_ar_len   = mst_ar_len[ar_gnt];
    assign slv_ar_size  = mst_ar_size[ar_gnt];
    assign slv_ar_burst = mst_ar_burst[ar_gnt];
    assign slv_ar_user  = mst_ar_user[ar_gnt];

    // Responses: stateless demux on the ID MSBs, payload broadcast to every master.
    assign b_sel       = slv_b_id[SID_W-1 -: MST_W];
    assign r_sel       = slv_r_id[SID_W-1 -: MST_W];
    assign slv_b_ready = mst_b_ready[b_sel];
    assign slv_r_ready = mst_r_ready[r_sel];

    always_comb begin
        mst_b_valid        = '0;
        mst_b_valid[b_sel] = slv_b_valid;
        mst_r_valid        = '0;
        mst_r_valid[r_sel] = slv_r_valid;
    end

    assign mst_b_id   = {NUM_MST{slv_b_id[ID_WIDTH-1:0]}};
    assign mst_b_resp = {NUM_MST{slv_b_resp}};
    assign mst_b_user = {NUM_MST{slv_b_user}};
    assign mst_r_id   = {NUM_MST{slv_r_id[ID_WIDTH-1:0]}};
    assign mst_r_data = {NUM_MST{slv_r_data}};
    assign mst_r_resp = {NUM_MST{slv_r_resp}};
    assign mst_r_last = {NUM_MST{slv_r_last}};
    assign mst_r_user = {NUM_MST{slv_r_user}};

endmodule

// File: tb/tb_nasti_mem_arbiter.sv
// Directed bench for nasti_mem_arbiter with two masters; the bench plays the memory slave.
module tb_nasti_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        mst_aw_valid, mst_aw_ready;
    logic [1:0][0:0]   mst_aw_id;
    logic [1:0][63:0]  mst_aw_addr;
    logic [1:0][7:0]   mst_aw_len;
    logic [1:0][2:0]   mst_aw_size;
    logic [1:0][1:0]   mst_aw_burst;
    logic [1:0][0:0]   mst_aw_user;
    logic [1:0]        mst_w_valid, mst_w_ready;
    logic [1:0][63:0]  mst_w_data;
    logic [1:0][7:0]   mst_w_strb;
    logic [1:0]        mst_w_last;
    logic [1:0][0:0]   mst_w_user;
    logic [1:0]        mst_b_valid, mst_b_ready;
    logic [1:0][0:0]   mst_b_id;
    logic [1:0][1:0]   mst_b_resp;
    logic [1:0][0:0]   mst_b_user;
    logic [1:0]        mst_ar_valid, mst_ar_ready;
    logic [1:0][0:0]   mst_ar_id;
    logic [1:0][63:0]  mst_ar_addr;
    logic [1:0][7:0]   mst_ar_len;
    logic [1:0][2:0]   mst_ar_size;
    logic [1:0][1:0]   mst_ar_burst;
    logic [1:0][0:0]   mst_ar_user;
    logic [1:0]        mst_r_valid, mst_r_ready;
    logic [1:0][0:0]   mst_r_id;
    logic [1:0][63:0]  mst_r_data;
    logic [1:0][1:0]   mst_r_resp;
    logic [1:0]        mst_r_last;
    logic [1:0][0:0]   mst_r_user;

    logic        slv_aw_valid, slv_aw_ready;
    logic [1:0]  slv_aw_id;
    logic [63:0] slv_aw_addr;
    logic [7:0]  slv_aw_len;
    logic [2:0]  slv_aw_size;
    logic [1:0]  slv_aw_burst;
    logic [0:0]  slv_aw_user;
    logic        slv_w_valid, slv_w_ready;
    logic [63:0] slv_w_data;
    logic [7:0]  slv_w_strb;
    logic        slv_w_last;
    logic [0:0]  slv_w_user;
    logic        slv_b_valid, slv_b_ready;
    logic [1:0]  slv_b_id;
    logic [1:0]  slv_b_resp;
    logic [0:0]  slv_b_user;
    logic        slv_ar_valid, slv_ar_ready;
    logic [1:0]  slv_ar_id;
    logic [63:0] slv_ar_addr;
    logic [7:0]  slv_ar_len;
    logic [2:0]  slv_ar_size;
    logic [1:0]  slv_ar_burst;
    logic [0:0]  slv_ar_user;
    logic        slv_r_valid, slv_r_ready;
    logic [1:0]  slv_r_id;
    logic [63:0] slv_r_data;
    logic [1:0]  slv_r_resp;
    logic        slv_r_last;
    logic [0:0]  slv_r_user;

    nasti_mem_arbiter #(.NUM_MST(2), .ID_WIDTH(1), .ADDR_WIDTH(64), .DATA_WIDTH(64), .USER_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready), .mst_aw_id(mst_aw_id),
        .mst_aw_addr(mst_aw_addr), .mst_aw_len(mst_aw_len), .mst_aw_size(mst_aw_size),
        .mst_aw_burst(mst_aw_burst), .mst_aw_user(mst_aw_user),
        .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready), .mst_w_data(mst_w_data),
        .mst_w_strb(mst_w_strb), .mst_w_last(mst_w_last), .mst_w_user(mst_w_user),
        .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready), .mst_b_id(mst_b_id),
        .mst_b_resp(mst_b_resp), .mst_b_user(mst_b_user),
        .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready), .mst_ar_id(mst_ar_id),
        .mst_ar_addr(mst_ar_addr), .mst_ar_len(mst_ar_len), .mst_ar_size(mst_ar_size),
        .mst_ar_burst(mst_ar_burst), .mst_ar_user(mst_ar_user),
        .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready), .mst_r_id(mst_r_id),
        .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_last(mst_r_last),
        .mst_r_user(mst_r_user),
        .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready), .slv_aw_id(slv_aw_id),
        .slv_aw_addr(slv_aw_addr), .slv_aw_len(slv_aw_len), .slv_aw_size(slv_aw_size),
        .slv_aw_burst(slv_aw_burst), .slv_aw_user(slv_aw_user),
        .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready), .slv_w_data(slv_w_data),
        .slv_w_strb(slv_w_strb), .slv_w_last(slv_w_last), .slv_w_user(slv_w_user),
        .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready), .slv_b_id(slv_b_id),
        .slv_b_resp(slv_b_resp), .slv_b_user(slv_b_user),
        .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready), .slv_ar_id(slv_ar_id),
        .slv_ar_addr(slv_ar_addr), .slv_ar_len(slv_ar_len), .slv_ar_size(slv_ar_size),
        .slv_ar_burst(slv_ar_burst), .slv_ar_user(slv_ar_user),
        .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready), .slv_r_id(slv_r_id),
        .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp), .slv_r_last(slv_r_last),
        .slv_r_user(slv_r_user)
    );

    // A forwarded request must hold valid until its handshake.
    a_aw_stable: assert property (@(posedge clk) disable iff (rst)
        (slv_aw_valid && !slv_aw_ready) |=> slv_aw_valid);
    a_ar_stable: assert property (@(posedge clk) disable iff (rst)
        (slv_ar_valid && !slv_ar_ready) |=> slv_ar_valid);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cnt [2];
    int ng;
    logic exp_m;

    initial begin
        rst = 1'b1;
        mst_aw_valid = '0; mst_aw_id = '0; mst_aw_addr = '0; mst_aw_len = '0;
        mst_aw_size = '0; mst_aw_burst = '0; mst_aw_user = '0;
        mst_w_valid = '0; mst_w_data = '0; mst_w_strb = '1; mst_w_last = '0; mst_w_user = '0;
        mst_b_ready = '0;
        mst_ar_valid = '0; mst_ar_id = '0; mst_ar_addr = '0; mst_ar_len = '0;
        mst_ar_size = '0; mst_ar_burst = '0; mst_ar_user = '0;
        mst_r_ready = '0;
        slv_aw_ready = 1'b1; slv_w_ready = 1'b1; slv_ar_ready = 1'b1;
        slv_b_valid = 1'b0; slv_b_id = '0; slv_b_resp = '0; slv_b_user = '0;
        slv_r_valid = 1'b0; slv_r_id = '0; slv_r_data = '0; slv_r_resp = '0;
        slv_r_last = 1'b0; slv_r_user = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        mst_b_ready = 2'b01;
        #1;
        chk("rst_aw_valid", slv_aw_valid, 0);
        chk("rst_w_valid", slv_w_valid, 0);
        chk("rst_ar_valid", slv_ar_valid, 0);
        chk("rst_aw_ready", mst_aw_ready, 0);
        chk("rst_w_ready", mst_w_ready, 0);
        chk("rst_ar_ready", mst_ar_ready, 0);
        chk("rst_b_ready_m0", slv_b_ready, 1);
        mst_b_ready = 2'b10;
        #1;
        chk("rst_b_ready_m1", slv_b_ready, 0);

        // single read from master 1
        mst_ar_valid = 2'b10; mst_ar_id[1] = 1'b1; mst_ar_addr[1] = 64'h1000; mst_ar_len[1] = 8'd3;
        #1;
        chk("rd_latency", slv_ar_valid, 0);
        tick();
        chk("rd_valid", slv_ar_valid, 1);
        chk("rd_id", slv_ar_id, 2'b11);
        chk("rd_addr", slv_ar_addr, 64'h1000);
        chk("rd_len", slv_ar_len, 3);
        chk("rd_ready", mst_ar_ready, 2'b10);
        tick();
        mst_ar_valid = '0;
        #1;
        chk("rd_done", slv_ar_valid, 0);
        mst_r_ready = 2'b10;
        for (int b = 0; b < 4; b++) begin
            slv_r_valid = 1'b1; slv_r_id = 2'b11; slv_r_data = 64'hC0 + 64'(b);
            slv_r_last = (b == 3);
            #1;
            chk("r_valid", mst_r_valid, 2'b10);
            chk("r_id", mst_r_id[1], 1);
            chk("r_data", mst_r_data[1], 64'hC0 + 64'(b));
            chk("r_last", mst_r_last[1], (b == 3));
            chk("r_slv_ready", slv_r_ready, 1);
            tick();
        end
        slv_r_valid = 1'b0; slv_r_last = 1'b0; mst_r_ready = '0;

        // read contention: expect strict 0,1,0,1 alternation
        cnt[0] = 0; cnt[1] = 0; ng = 0; exp_m = 1'b0;
        mst_ar_id[0] = 1'b0; mst_ar_id[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            mst_ar_valid[0] = (cnt[0] < 4);
            mst_ar_valid[1] = (cnt[1] < 4);
            #1;
            if (slv_ar_valid) begin
                chk("rd_order", slv_ar_id[1], exp_m);
                cnt[slv_ar_id[1]]++;
                ng++;
                exp_m = ~exp_m;
            end
            tick();
        end
        mst_ar_valid = '0;
        chk("rd_grants", ng, 8);

        // write lock: master 0 burst of 8 while master 1 waits
        mst_aw_valid = 2'b11; mst_aw_id[0] = 1'b0; mst_aw_id[1] = 1'b1;
        mst_aw_len[0] = 8'd7; mst_aw_len[1] = 8'd0;
        mst_aw_addr[0] = 64'h2000; mst_aw_addr[1] = 64'h3000;
        #1;
        chk("aw_idle_ready", mst_aw_ready, 0);
        tick();
        chk("aw0_valid", slv_aw_valid, 1);
        chk("aw0_id", slv_aw_id, 2'b00);
        chk("aw0_len", slv_aw_len, 7);
        chk("aw0_ready", mst_aw_ready, 2'b01);
        tick();
        mst_aw_valid = 2'b10;
        for (int b = 0; b < 8; b++) begin
            mst_w_valid = 2'b11;
            mst_w_data[0] = 64'hA0 + 64'(b); mst_w_last[0] = (b == 7);
            mst_w_data[1] = 64'hDEAD;        mst_w_last[1] = 1'b1;
            #1;
            chk("w0_ready", mst_w_ready, 2'b01);
            chk("w0_data", slv_w_data, 64'hA0 + 64'(b));
            chk("w0_last", slv_w_last, (b == 7));
            chk("aw1_blocked", mst_aw_ready, 0);
            tick();
        end
        mst_w_valid = 2'b10;
        #1;
        chk("w_gap_valid", slv_w_valid, 0);
        chk("w_gap_aw_ready", mst_aw_ready, 0);
        tick();
        chk("aw1_id", slv_aw_id, 2'b11);
        chk("aw1_ready", mst_aw_ready, 2'b10);
        tick();
        mst_aw_valid = '0;
        #1;
        chk("w1_ready", mst_w_ready, 2'b10);
        chk("w1_data", slv_w_data, 64'hDEAD);
        tick();
        mst_w_valid = '0;

        // interleaved B responses with backpressure on master 1
        slv_b_valid = 1'b1; slv_b_id = 2'b11; slv_b_resp = 2'd2; mst_b_ready = 2'b11;
        #1;
        chk("b1_valid", mst_b_valid, 2'b10);
        chk("b1_id", mst_b_id[1], 1);
        chk("b1_resp", mst_b_resp[1], 2);
        chk("b1_ready", slv_b_ready, 1);
        mst_b_ready = 2'b01;
        #1;
        chk("b1_stall", slv_b_ready, 0);
        mst_b_ready = 2'b11;
        tick();
        slv_b_id = 2'b00; slv_b_resp = 2'd1;
        #1;
        chk("b0_valid", mst_b_valid, 2'b01);
        chk("b0_id", mst_b_id[0], 0);
        chk("b0_resp", mst_b_resp[0], 1);
        chk("b0_ready", slv_b_ready, 1);
        tick();
        slv_b_valid = 1'b0;
        #1;
        chk("b_quiet", mst_b_valid, 0);

        // concurrent AW and AR from master 0
        mst_aw_valid = 2'b01; mst_aw_len[0] = 8'd0; mst_ar_valid = 2'b01;
        #1;
        chk("cc_idle", {slv_aw_valid, slv_ar_valid}, 2'b00);
        tick();
        chk("cc_both", {slv_aw_valid, slv_ar_valid}, 2'b11);
        chk("cc_aw_id", slv_aw_id, 2'b00);
        chk("cc_ar_id", slv_ar_id, 2'b00);
        tick();
        mst_aw_valid = '0; mst_ar_valid = '0;
        mst_w_valid = 2'b01; mst_w_last[0] = 1'b1; mst_w_data[0] = 64'h55;
        #1;
        chk("cc_w_valid", slv_w_valid, 1);
        tick();
        mst_w_valid = '0;

        // reset mid-burst: master 1 burst of 8, reset at beat 3
        mst_aw_valid = 2'b10; mst_aw_len[1] = 8'd7;
        tick();
        tick();
        mst_aw_valid = '0;
        for (int b = 0; b < 3; b++) begin
            mst_w_valid = 2'b10; mst_w_last[1] = 1'b0; mst_w_data[1] = 64'(b);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mr_w_valid", slv_w_valid, 0);
        chk("mr_w_ready", mst_w_ready, 0);
        chk("mr_aw_ready", mst_aw_ready, 0);
        chk("mr_ar_ready", mst_ar_ready, 0);
        mst_aw_valid = 2'b11;
        tick();
        chk("mr_next_grant", slv_aw_id[1], 0);
        chk("mr_w_held", slv_w_valid, 0);
        mst_aw_valid = '0; mst_w_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
